abus_arbiter: RTL and testbench
===============================

Name: abus_arbiter

Overview:
- Round-robin arbiter that shares one ABus-style bus (req/gnt handshake, driven lines b and c, turnaround-sensitive inout d) among NUM_REQ synchronous requesters, such as two testbench STB ports on the same bus instance.
- Issues one-hot grants and muxes the owner's b/c drive onto the shared bus.
- Enforces a maximum hold time and a one-cycle turnaround between owners.
- Sits beside the bus interface instance in top-level and bench wrappers.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester is waiting; legal range 2..255.
- IDX_W, derived localparam, max(1, $clog2(NUM_REQ)); not overridable.

Ports:
- clk  input  1  bus clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- b_in  input  NUM_REQ  per-requester value for bus line b.
- c_in  input  NUM_REQ  per-requester value for bus line c.
- gnt  output  NUM_REQ  one-hot grant, registered.
- owner  output  IDX_W  index of current owner, registered; valid only while busy=1.
- busy  output  1  high while any gnt bit is high.
- b_out  output  1  shared bus b.
- c_out  output  1  shared bus c.
- d_oe  output  NUM_REQ  per-requester output enable for d; equals gnt.
- preempt  output  1  one-cycle pulse when a grant is removed by the hold limit.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - gnt=0, busy=0, owner=0, preempt=0, hold_cnt=0, state=IDLE.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, GRANT, TURN.
- Winner selection: first set bit of req, scanning indices last+1, last+2, … modulo NUM_REQ.
- IDLE:
  - If req≠0 at an edge, the winner's gnt is set at that edge, owner=winner, hold_cnt=0, next state GRANT.
  - Grant latency from the first sampled req is therefore exactly 1 cycle.
- GRANT:
  - hold_cnt increments each cycle, saturating at MAX_HOLD.
  - req[owner]=0 at an edge: gnt clears, last=owner, next state TURN.
  - hold_cnt=MAX_HOLD-1 and any other req bit set: gnt clears, preempt pulses for 1 cycle, last=owner, next state TURN.
  - hold_cnt=MAX_HOLD-1 and no other requester: hold_cnt restarts at 0, grant continues, no preempt.
- TURN:
  - Exactly one cycle with gnt=0 (d turnaround).
  - At its closing edge, if req≠0, the winner is granted and state goes to GRANT; otherwise IDLE.
  - The previous owner may win again only if no other requester is asserting.
- Bus outputs:
  - b_out=b_in[owner] and c_out=c_in[owner] while busy, else 0.
  - These are combinational from registered owner/busy and the inputs; no added latency.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt never changes owner without an intervening all-zero cycle.
- Worst-case wait for a continuously asserting requester: (NUM_REQ-1)*(MAX_HOLD+1)+1 cycles.
- A requester that drops req before being granted is simply skipped; no sticky request.
- A req pulse of 1 cycle in IDLE still yields a grant.
  - The grant is released the next edge, since req[owner]=0.
  - The requester sees gnt for exactly 1 cycle.
- Simultaneous release and new request in GRANT: the release is taken first, then TURN, then the new grant.
- Reset mid-grant: gnt and b_out/c_out drop asynchronously; the pointer returns to NUM_REQ-1.

Test Plan:
- Reset, then req=2'b01 held 4 cycles and dropped → gnt=01 one cycle after req, held 4 cycles, then one TURN cycle with gnt=00 → IDLE; busy mirrors gnt.
- req=2'b11 raised together from IDLE → gnt=01 first (pointer 1).
  - Requester 0 drops req after 3 grant cycles → 1 TURN cycle → gnt=10.
  - Holding req=11 continuously alternates 0,1,0 with each tenure ≤ MAX_HOLD=8 cycles, separated by single gnt=00 cycles.
- req0 held 20 cycles alone with MAX_HOLD=8 → gnt=01 uninterrupted, preempt never pulses.
  - req1 raised at cycle 12 → preempt pulses at the end of the current 8-cycle tenure, TURN, then gnt=10.
- With gnt=10, b_in=2'b10 and c_in=2'b01 → b_out=1, c_out=0; d_oe=10; while IDLE, b_out=c_out=0 regardless of b_in/c_in.
- Assert rst mid-grant (gnt=10) → gnt, busy, b_out, preempt=0 immediately, without waiting for a clock edge.
  - After release with req=11 → requester 0 is granted first.
- NUM_REQ=4 with all req held → grant order 0,1,2,3,0 with one gnt=0000 cycle between tenures.
  - Assertion check: gnt is one-hot or zero, and every req is granted within the worst-case wait bound above.

Source files
------------

// File: rtl/abus_arbiter_if.sv
// Arbiter-side bundle for a shared ABus: per-requester request/drive lines
// and the granted, muxed bus lines.
interface abus_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] b_in;
    logic [NUM_REQ-1:0] c_in;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] d_oe;
    logic [IDX_W-1:0]   owner;
    logic               busy;
    logic               b_out;
    logic               c_out;
    logic               preempt;

    modport master (
        output req, b_in, c_in,
        input  gnt, d_oe, owner, busy, b_out, c_out, preempt
    );

    modport slave (
        input  req, b_in, c_in,
        output gnt, d_oe, owner, busy, b_out, c_out, preempt
    );
endinterface

// File: rtl/abus_arbiter.sv
// Round-robin ABus arbiter: one-hot registered grants, hold-time preemption
// and a mandatory one-cycle turnaround between owners.
module abus_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst,
    abus_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_q;
    logic [7:0]         hold_q;
    logic               busy_q;
    logic               preempt_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     scan_idx;
    logic [NUM_REQ-1:0] req_others;

    // Scan last+1, last+2, ... wrapping, so the previous owner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            scan_idx = {1'b0, last_q} + (IDX_W + 1)'(i);
            if (scan_idx >= (IDX_W + 1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W + 1)'(NUM_REQ);
            end
            if (!win_found && bus.req[scan_idx[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req_others          = bus.req;
        req_others[owner_q] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                StIdle, StTurn: begin
                    if (win_found) begin
                        gnt_q   <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << win_idx;
                        owner_q <= win_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        state_q <= StGrant;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    if (!bus.req[owner_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= owner_q;
                        state_q <= StTurn;
                    end else if (hold_q == 8'(MAX_HOLD - 1)) begin
                        // Hold limit only bites when someone else is waiting.
                        if (|req_others) begin
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                            preempt_q <= 1'b1;
                            last_q    <= owner_q;
                            state_q   <= StTurn;
                        end else begin
                            hold_q <= '0;
                        end
                    end else if (hold_q != 8'(MAX_HOLD)) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.d_oe    = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
    assign bus.b_out   = busy_q & bus.b_in[owner_q];
    assign bus.c_out   = busy_q & bus.c_in[owner_q];
endmodule

// File: tb/tb_abus_arbiter.sv
// Directed bench for abus_arbiter: a 2-requester instance (MAX_HOLD=8) and a
// 4-requester instance (MAX_HOLD=3) sharing clock and reset.
module tb_abus_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   wait2 [2];
    int   wait4 [4];

    abus_arbiter_if #(.NUM_REQ(2)) a_if ();
    abus_arbiter_if #(.NUM_REQ(4)) q_if ();

    abus_arbiter #(.NUM_REQ(2), .MAX_HOLD(8)) u_dut2 (
        .clk(clk),
        .rst(rst),
        .bus(a_if)
    );

    abus_arbiter #(.NUM_REQ(4), .MAX_HOLD(3)) u_dut4 (
        .clk(clk),
        .rst(rst),
        .bus(q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Zero/one-hot grants and the worst-case wait bound, (N-1)*(MAX_HOLD+1)+1.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            assert ($onehot0(a_if.gnt)) else begin
                n_err++;
                $error("FAIL onehot2: got %b expected zero or one-hot", a_if.gnt);
            end
            n_cmp++;
            assert ($onehot0(q_if.gnt)) else begin
                n_err++;
                $error("FAIL onehot4: got %b expected zero or one-hot", q_if.gnt);
            end
            for (int i = 0; i < 2; i++) begin
                if (a_if.req[i] && !a_if.gnt[i]) wait2[i]++;
                else wait2[i] = 0;
                n_cmp++;
                assert (wait2[i] <= 10) else begin
                    n_err++;
                    $error("FAIL wait2[%0d]: got %0d expected <= 10", i, wait2[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (q_if.req[i] && !q_if.gnt[i]) wait4[i]++;
                else wait4[i] = 0;
                n_cmp++;
                assert (wait4[i] <= 13) else begin
                    n_err++;
                    $error("FAIL wait4[%0d]: got %0d expected <= 13", i, wait4[i]);
                end
            end
        end else begin
            wait2 = '{default: 0};
            wait4 = '{default: 0};
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a_if.req = '0; a_if.b_in = '0; a_if.c_in = '0;
        q_if.req = '0; q_if.b_in = '0; q_if.c_in = '0;
        #1;
        chk("rst_gnt", 8'(a_if.gnt), 8'h0);
        chk("rst_busy", 8'(a_if.busy), 8'h0);
        chk("rst_owner", 8'(a_if.owner), 8'h0);
        chk("rst_preempt", 8'(a_if.preempt), 8'h0);
        chk("rst_bout", 8'(a_if.b_out), 8'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("idle_gnt", 8'(a_if.gnt), 8'h0);

        // Single requester, 4-cycle tenure, release, turnaround, idle.
        a_if.req = 2'b01;
        tick(1);
        chk("t1_gnt", 8'(a_if.gnt), 8'h1);
        chk("t1_busy", 8'(a_if.busy), 8'h1);
        chk("t1_owner", 8'(a_if.owner), 8'h0);
        chk("t1_doe", 8'(a_if.d_oe), 8'h1);
        tick(3);
        chk("t1_hold", 8'(a_if.gnt), 8'h1);
        a_if.req = 2'b00;
        tick(1);
        chk("t1_rel_gnt", 8'(a_if.gnt), 8'h0);
        chk("t1_rel_busy", 8'(a_if.busy), 8'h0);
        tick(1);
        chk("t1_idle", 8'(a_if.gnt), 8'h0);
        a_if.b_in = 2'b11; a_if.c_in = 2'b11;
        #1;
        chk("idle_bout", 8'(a_if.b_out), 8'h0);
        chk("idle_cout", 8'(a_if.c_out), 8'h0);
        a_if.b_in = '0; a_if.c_in = '0;

        // One-cycle request pulse still gets exactly one grant cycle.
        a_if.req = 2'b10;
        tick(1);
        chk("pulse_gnt", 8'(a_if.gnt), 8'h2);
        a_if.req = 2'b00;
        tick(1);
        chk("pulse_rel", 8'(a_if.gnt), 8'h0);

        // Both request from reset: 0 first, voluntary release, then alternation.
        do_reset();
        a_if.req = 2'b11;
        tick(1);
        chk("t2_first", 8'(a_if.gnt), 8'h1);
        tick(2);
        chk("t2_first_hold", 8'(a_if.gnt), 8'h1);
        a_if.req = 2'b10;
        tick(1);
        chk("t2_turn", 8'(a_if.gnt), 8'h0);
        chk("t2_turn_pre", 8'(a_if.preempt), 8'h0);
        tick(1);
        chk("t2_second", 8'(a_if.gnt), 8'h2);
        chk("t2_owner", 8'(a_if.owner), 8'h1);
        a_if.b_in = 2'b10; a_if.c_in = 2'b01;
        #1;
        chk("mux_bout", 8'(a_if.b_out), 8'h1);
        chk("mux_cout", 8'(a_if.c_out), 8'h0);
        chk("mux_doe", 8'(a_if.d_oe), 8'h2);
        a_if.req = 2'b11;
        tick(7);
        chk("t2_r1_hold", 8'(a_if.gnt), 8'h2);
        chk("t2_r1_nopre", 8'(a_if.preempt), 8'h0);
        a_if.b_in = 2'b11; a_if.c_in = 2'b11;
        tick(1);
        chk("t2_pre_gnt", 8'(a_if.gnt), 8'h0);
        chk("t2_pre", 8'(a_if.preempt), 8'h1);
        chk("turn_bout", 8'(a_if.b_out), 8'h0);
        chk("turn_cout", 8'(a_if.c_out), 8'h0);
        tick(1);
        chk("t2_r0", 8'(a_if.gnt), 8'h1);
        chk("t2_r0_pre", 8'(a_if.preempt), 8'h0);
        tick(7);
        chk("t2_r0_hold", 8'(a_if.gnt), 8'h1);
        tick(1);
        chk("t2_pre2_gnt", 8'(a_if.gnt), 8'h0);
        chk("t2_pre2", 8'(a_if.preempt), 8'h1);
        tick(1);
        chk("t2_r1_again", 8'(a_if.gnt), 8'h2);

        // Lone holder is never preempted; a late competitor preempts at tenure end.
        a_if.req = 2'b00; a_if.b_in = '0; a_if.c_in = '0;
        do_reset();
        a_if.req = 2'b01;
        tick(1);
        chk("t3_gnt", 8'(a_if.gnt), 8'h1);
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            chk("t3_alone", {6'd0, a_if.preempt, a_if.gnt[0] ^ a_if.gnt[1]}, 8'h1);
            chk("t3_alone_gnt", 8'(a_if.gnt), 8'h1);
        end
        a_if.req = 2'b11;
        for (int k = 12; k <= 15; k++) begin
            tick(1);
            chk("t3_contend_gnt", 8'(a_if.gnt), 8'h1);
            chk("t3_contend_pre", 8'(a_if.preempt), 8'h0);
        end
        tick(1);
        chk("t3_pre_gnt", 8'(a_if.gnt), 8'h0);
        chk("t3_pre", 8'(a_if.preempt), 8'h1);
        tick(1);
        chk("t3_next", 8'(a_if.gnt), 8'h2);
        chk("t3_next_owner", 8'(a_if.owner), 8'h1);

        // Asynchronous reset mid-grant.
        a_if.b_in = 2'b11;
        #1;
        chk("t4_bout_pre", 8'(a_if.b_out), 8'h1);
        rst = 1'b1;
        #1;
        chk("t4_gnt", 8'(a_if.gnt), 8'h0);
        chk("t4_busy", 8'(a_if.busy), 8'h0);
        chk("t4_bout", 8'(a_if.b_out), 8'h0);
        chk("t4_preempt", 8'(a_if.preempt), 8'h0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("t4_after", 8'(a_if.gnt), 8'h1);
        a_if.req = 2'b00; a_if.b_in = '0;
        tick(2);

        // Four requesters, all asserting: 0,1,2,3,0 with a gap between tenures.
        q_if.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("t5_grant", 8'(q_if.gnt), 8'(4'b0001 << (k % 4)));
            tick(2);
            chk("t5_hold", 8'(q_if.gnt), 8'(4'b0001 << (k % 4)));
            tick(1);
            chk("t5_gap", 8'(q_if.gnt), 8'h0);
            chk("t5_pre", 8'(q_if.preempt), 8'h1);
        end
        q_if.req = '0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
